uart_tx: RTL

Serial UART transmitter: accepts one 8-bit byte per request and emits it on `tx` as a standard asynchronous frame. The frame is a start bit, 8 data bits LSB first, an optional parity bit, and 1 or 2 stop bits. It pairs with the UART receiver in the same design, sharing `clk_freq`/`baud_rate` so both ends agree on bit period. Bit timing uses a clock-enable counter on `clk`; no derived clocks.

---
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_tx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Handshake bundle between a byte producer and the UART transmitter.
// The master drives requests; the transmitter (slave) returns the line and status.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       donetx;

    modport master (output tx_start, tx_data, input tx, tx_busy, donetx);
    modport slave  (input tx_start, tx_data, output tx, tx_busy, donetx);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit timing comes from a clock-enable counter on clk; every output is registered.
module uart_tx #(
    parameter int clk_freq   = 1000000,
    parameter int baud_rate  = 9600,
    parameter bit parity_en  = 1'b0,
    parameter bit parity_odd = 1'b0,
    parameter int stop_bits  = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam int CPB  = clk_freq / baud_rate;
    localparam int CNTW = $clog2(CPB);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   baudCnt_q, baudCnt_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              lastTick;

    assign lastTick = (baudCnt_q == CNTW'(CPB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Parity is taken from the byte at acceptance, so later tx_data changes cannot leak in.
    // bitIdx doubles as the stop-bit counter once the data bits are out.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        tx_d      = 1'b1;

        if (state_q != IDLE) begin
            baudCnt_d = lastTick ? '0 : baudCnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    state_d   = START;
                    shreg_d   = bus.tx_data;
                    parity_d  = (^bus.tx_data) ^ parity_odd;
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                end
            end
            START: begin
                if (lastTick) state_d = DATA;
            end
            DATA: begin
                if (lastTick) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        bitIdx_d = '0;
                        state_d  = parity_en ? PARITY : STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (lastTick) state_d = STOP;
            end
            STOP: begin
                if (lastTick) begin
                    if (bitIdx_q == 3'(stop_bits - 1)) begin
                        state_d  = IDLE;
                        bitIdx_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign busy_d      = (state_d != IDLE);
    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.donetx  = done_q;

endmodule
